// File: rtl/uart_mem_loader.sv
// uart_mem_loader: boot-time program loader.
//
// Receives an 8N1 serial byte stream, parses a 16-bit big-endian word count N
// followed by N big-endian 16-bit words, and writes each word into unified
// memory through the IO write port at BASE_ADDR + i (wrapping mod 2^16).
// The CPU is held stalled until the whole image has been written.
//
// Optional feature macro: LOADER_VERIFY_EN
//   When defined, each written word is read back through RADDR_IO/DATA_OUT_IO.
//   Read data arrives two cycles after the write.
//   A mismatch is a load error.
//   When undefined, RADDR_IO is tied to 0 and DATA_OUT_IO is ignored.
//
// Handshake: there is no backpressure on the serial side. Internally, byte
// valid is a one-cycle pulse that the loader must take in that cycle. The one
// exception is a byte that lands while the loader is writing or verifying.
// That byte is parked in a single pending slot and taken at the next
// byte-accepting state.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   RXD         asynchronous serial input, idle high
//   WADDR_IO    memory IO write address (holds last value)
//   DATA_IN_IO  memory IO write data (holds last value)
//   MW_IO_ON    memory IO write strobe, one-cycle pulse
//   RADDR_IO    memory IO read address (verify build only, else 0)
//   DATA_OUT_IO memory IO read data (verify build only)
//   CPU_HOLD    high while the CPU must not fetch or retire
//   LOAD_DONE   sticky, image fully written
//   LOAD_ERR    sticky, framing or verify error
//   rx_state    debug view of the receiver FSM state
//   ld_state    debug view of the loader FSM state

module uart_mem_loader #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [15:0] BASE_ADDR    = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RXD,
    output logic [15:0] WADDR_IO,
    output logic [15:0] DATA_IN_IO,
    output logic        MW_IO_ON,
    output logic [15:0] RADDR_IO,
    input  logic [15:0] DATA_OUT_IO,
    output logic        CPU_HOLD,
    output logic        LOAD_DONE,
    output logic        LOAD_ERR,
    output logic [1:0]  rx_state,
    output logic [3:0]  ld_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    typedef enum logic [3:0] {
        CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, VWAIT, VERIFY, DONE, ERROR
    } ld_state_t;

    // ---------------- input synchronizer ----------------
    logic sync1, rx_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= RXD;
            rx_s  <= sync1;
        end
    end

    // ---------------- receiver FSM ----------------
    rx_state_t     rx_st, rx_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shreg, shreg_next;
    logic          byte_pulse, frame_pulse;
    logic          byte_valid, frame_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_st      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_st      <= rx_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_next;
            shreg      <= shreg_next;
            byte_valid <= byte_pulse;
            frame_err  <= frame_pulse;
        end
    end

    always_comb begin
        rx_next     = rx_st;
        cnt_next    = cnt;
        bit_next    = bit_idx;
        shreg_next  = shreg;
        byte_pulse  = 1'b0;
        frame_pulse = 1'b0;
        case (rx_st)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_next  = RX_START;
                    cnt_next = '0;
                end
            end
            RX_START: begin
                // Mid start bit: a high line here means the low was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    bit_next = '0;
                    rx_next  = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_s, shreg[7:1]};
                    if (bit_idx == 3'd7) rx_next  = RX_STOP;
                    else                 bit_next = bit_idx + 3'd1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RX_STOP: begin
                // Returning to idle mid stop bit leaves half a bit of margin
                // to catch the next start edge of a back-to-back frame.
                if (cnt == FULL_LAST) begin
                    cnt_next = '0;
                    rx_next  = RX_IDLE;
                    if (rx_s) byte_pulse  = 1'b1;
                    else      frame_pulse = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // ---------------- loader FSM ----------------
    ld_state_t   ld_st, ld_next;
    logic [15:0] count_q, idx_q, waddr_q, data_q;
    logic [7:0]  word_hi, pend_byte, byte_in;
    logic        pend_valid, byte_avail, accepting, err_event;
    logic        verify_bad;

    assign accepting  = (ld_st == CNT_HI) || (ld_st == CNT_LO) ||
                        (ld_st == DAT_HI) || (ld_st == DAT_LO);
    assign byte_avail = byte_valid || pend_valid;
    assign byte_in    = pend_valid ? pend_byte : shreg;
    assign err_event  = frame_err && (ld_st != DONE) && (ld_st != ERROR);

`ifdef LOADER_VERIFY_EN
    assign verify_bad = (DATA_OUT_IO != data_q);
    assign RADDR_IO   = (ld_st == WRITE) ? waddr_q : 16'h0000;
`else
    logic unused_read;
    assign unused_read = ^DATA_OUT_IO;
    assign verify_bad  = 1'b0;
    assign RADDR_IO    = 16'h0000;
`endif

    always_comb begin
        ld_next = ld_st;
        case (ld_st)
            CNT_HI: if (byte_avail) ld_next = CNT_LO;
            CNT_LO: if (byte_avail)
                        ld_next = ({count_q[15:8], byte_in} == 16'h0000) ? DONE : DAT_HI;
            DAT_HI: if (byte_avail) ld_next = DAT_LO;
            DAT_LO: if (byte_avail) ld_next = WRITE;
`ifdef LOADER_VERIFY_EN
            WRITE:  ld_next = VWAIT;
            VWAIT:  ld_next = VERIFY;
            // idx_q was already advanced in WRITE.
            VERIFY: ld_next = verify_bad ? ERROR :
                              (idx_q == count_q) ? DONE : DAT_HI;
`else
            WRITE:  ld_next = ((idx_q + 16'd1) == count_q) ? DONE : DAT_HI;
`endif
            DONE:   ld_next = DONE;
            ERROR:  ld_next = ERROR;
            default: ld_next = ERROR;
        endcase
        if (err_event) ld_next = ERROR;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_st      <= CNT_HI;
            count_q    <= '0;
            idx_q      <= '0;
            word_hi    <= '0;
            waddr_q    <= BASE_ADDR;
            data_q     <= '0;
            pend_valid <= 1'b0;
            pend_byte  <= '0;
        end else begin
            ld_st <= ld_next;

            if (accepting) begin
                pend_valid <= 1'b0;
            end else if (byte_valid && (ld_st != DONE) && (ld_st != ERROR)) begin
                pend_valid <= 1'b1;
                pend_byte  <= shreg;
            end

            if (byte_avail) begin
                case (ld_st)
                    CNT_HI: count_q[15:8] <= byte_in;
                    CNT_LO: begin
                        count_q[7:0] <= byte_in;
                        idx_q        <= '0;
                    end
                    DAT_HI: word_hi <= byte_in;
                    DAT_LO: begin
                        waddr_q <= BASE_ADDR + idx_q;
                        data_q  <= {word_hi, byte_in};
                    end
                    default: ;
                endcase
            end

            if (ld_st == WRITE) idx_q <= idx_q + 16'd1;
        end
    end

    assign WADDR_IO   = waddr_q;
    assign DATA_IN_IO = data_q;
    assign MW_IO_ON   = (ld_st == WRITE);
    assign CPU_HOLD   = (ld_st != DONE);
    assign LOAD_DONE  = (ld_st == DONE);
    assign LOAD_ERR   = (ld_st == ERROR);
    assign rx_state   = rx_st;
    assign ld_state   = ld_st;

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: directed bench for uart_mem_loader at CLKS_PER_BIT=4.
//
// dut1 uses BASE_ADDR=0000 and is backed by a small write-first memory model
// with two-cycle read latency. dut2 uses BASE_ADDR=FFFF and its memory read
// data is tied to 0000. dut2 stays in reset until the wrap-around step.
// Both instances share the serial line.

module tb_uart_mem_loader;

    localparam int CPB = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    logic rxd = 1'b1;

    always #5 clk = ~clk;

    // ---------------- dut1 ----------------
    logic [15:0] waddr, data_in, raddr, data_out;
    logic        mw, hold, done, err;
    logic [1:0]  rx_st;
    logic [3:0]  ld_st;

    uart_mem_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0000)) dut1 (
        .CLK(clk), .RST(rst), .RXD(rxd),
        .WADDR_IO(waddr), .DATA_IN_IO(data_in), .MW_IO_ON(mw),
        .RADDR_IO(raddr), .DATA_OUT_IO(data_out),
        .CPU_HOLD(hold), .LOAD_DONE(done), .LOAD_ERR(err),
        .rx_state(rx_st), .ld_state(ld_st)
    );

    // ---------------- dut2 ----------------
    logic [15:0] waddr2, data_in2, raddr2;
    logic        mw2, hold2, done2, err2;
    logic [1:0]  rx_st2;
    logic [3:0]  ld_st2;

    uart_mem_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'hFFFF)) dut2 (
        .CLK(clk), .RST(rst2), .RXD(rxd),
        .WADDR_IO(waddr2), .DATA_IN_IO(data_in2), .MW_IO_ON(mw2),
        .RADDR_IO(raddr2), .DATA_OUT_IO(16'h0000),
        .CPU_HOLD(hold2), .LOAD_DONE(done2), .LOAD_ERR(err2),
        .rx_state(rx_st2), .ld_state(ld_st2)
    );

    // ---------------- memory model for dut1 ----------------
    logic [15:0] mem [256];
    logic [15:0] rd1, rd2;

    always @(posedge clk) begin
        if (mw) mem[waddr[7:0]] <= data_in;
        rd1 <= (mw && (waddr == raddr)) ? data_in : mem[raddr[7:0]];
        rd2 <= rd1;
    end
    assign data_out = rd2;

    // ---------------- write monitors ----------------
    logic [15:0] wa_q[$], wd_q[$], wa2_q[$], wd2_q[$];
    int cyc = 0;
    int last_mw_cyc = -1;
    int done_cyc = -1;
    int double_cnt = 0;
    logic prev_mw = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mw) begin
            wa_q.push_back(waddr);
            wd_q.push_back(data_in);
            last_mw_cyc = cyc;
        end
        if (mw && prev_mw) double_cnt++;
        prev_mw = mw;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (mw2) begin
            wa2_q.push_back(waddr2);
            wd2_q.push_back(data_in2);
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_time(input logic v);
        rxd = v;
        repeat (CPB) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        rxd = 1'b1;
    endtask

    task automatic reset_dut1();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
        last_mw_cyc = -1;
        done_cyc = -1;
        double_cnt = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) tick();
        reset_dut1();

        // Reset values on the first cycle after reset
        @(negedge clk);
        check("rst_hold", hold, 1);
        check("rst_mw", mw, 0);
        check("rst_waddr", waddr, 16'h0000);
        check("rst_data", data_in, 16'h0000);
        check("rst_raddr", raddr, 16'h0000);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        tick();

        // Two-word image, back-to-back frames
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        repeat (20) tick();
        @(negedge clk);
        check("img2_nwrites", wa_q.size(), 2);
        check("img2_a0", wa_q[0], 16'h0000);
        check("img2_d0", wd_q[0], 16'h1234);
        check("img2_a1", wa_q[1], 16'h0001);
        check("img2_d1", wd_q[1], 16'hABCD);
        check("img2_done", done, 1);
        check("img2_hold", hold, 0);
        check("img2_err", err, 0);
        check("img2_done_lat", done_cyc, last_mw_cyc + 1);
        check("img2_no_double", double_cnt, 0);
        check("img2_waddr_hold", waddr, 16'h0001);
        check("img2_data_hold", data_in, 16'hABCD);

        // Zero-length image, then a stray byte
        reset_dut1();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (10) tick();
        @(negedge clk);
        check("zero_nwrites", wa_q.size(), 0);
        check("zero_done", done, 1);
        check("zero_hold", hold, 0);
        tick();
        send_byte(8'h55, 1'b1);
        repeat (10) tick();
        @(negedge clk);
        check("zero_ignore_nwrites", wa_q.size(), 0);
        check("zero_ignore_done", done, 1);
        check("zero_ignore_err", err, 0);
        check("zero_ignore_waddr", waddr, 16'h0000);

        // One-cycle low glitch, then a one-word image
        reset_dut1();
        rxd = 1'b0;
        tick();
        rxd = 1'b1;
        repeat (12) tick();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        repeat (20) tick();
        @(negedge clk);
        check("glitch_nwrites", wa_q.size(), 1);
        check("glitch_a0", wa_q[0], 16'h0000);
        check("glitch_d0", wd_q[0], 16'hBEEF);
        check("glitch_err", err, 0);
        check("glitch_done", done, 1);

        // Framing error during the data phase
        reset_dut1();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        repeat (20) tick();
        @(negedge clk);
        check("ferr_err", err, 1);
        check("ferr_hold", hold, 1);
        check("ferr_done", done, 0);
        check("ferr_nwrites", wa_q.size(), 0);
        tick();
        reset_dut1();
        @(negedge clk);
        check("ferr_rst_err", err, 0);
        check("ferr_rst_hold", hold, 1);
        check("ferr_rst_done", done, 0);
        tick();

        // Address wrap on dut2 (dut1 parked in reset)
        rst = 1'b1;
        rst2 = 1'b0;
        repeat (3) tick();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (20) tick();
        @(negedge clk);
        check("wrap_a0", wa2_q[0], 16'hFFFF);
        check("wrap_d0", wd2_q[0], 16'h1111);
`ifdef LOADER_VERIFY_EN
        check("wrap_v_nwrites", wa2_q.size(), 1);
        check("wrap_v_err", err2, 1);
        check("wrap_v_hold", hold2, 1);
        check("wrap_v_done", done2, 0);
`else
        check("wrap_nwrites", wa2_q.size(), 2);
        check("wrap_a1", wa2_q[1], 16'h0000);
        check("wrap_d1", wd2_q[1], 16'h2222);
        check("wrap_done", done2, 1);
        check("wrap_hold", hold2, 0);
        check("wrap_err", err2, 0);
        check("wrap_raddr", raddr2, 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Boot-time program loader on the memory IO side of the 16-bit pipelined CPU.
- Receives a serial 8N1 byte stream and assembles 16-bit words.
- Writes the words into unified memory through the IO write port (WADDR_IO / DATA_IN_IO / MW_IO_ON).
- Holds the CPU pipeline in reset-equivalent stall (CPU_HOLD) until the image is complete.

Parameters:
CLKS_PER_BIT, 16, CLK cycles per UART bit; must be even and >= 4
BASE_ADDR, 16'h0000, memory word address of the first loaded word

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
RXD  input  1  asynchronous serial input, idle high
WADDR_IO  output  16  memory IO write address
DATA_IN_IO  output  16  memory IO write data
MW_IO_ON  output  1  memory IO write strobe, one-cycle pulse
RADDR_IO  output  16  memory IO read address (used only with LOADER_VERIFY_EN, else tied to 0)
DATA_OUT_IO  input  16  memory IO read data (used only with LOADER_VERIFY_EN)
CPU_HOLD  output  1  high = CPU must not fetch or retire
LOAD_DONE  output  1  sticky, image fully written
LOAD_ERR  output  1  sticky, framing or verify error

Behaviour:
- Reset values: WADDR_IO=BASE_ADDR, DATA_IN_IO=0, MW_IO_ON=0, RADDR_IO=0, CPU_HOLD=1, LOAD_DONE=0, LOAD_ERR=0. Reset mid-byte or mid-image aborts everything and returns to CNT_HI and RX_IDLE.
- RXD passes a 2-flop synchronizer (2-cycle input latency) before use.
- RX FSM states:
  - RX_IDLE: waits for synced RXD=0.
  - RX_START: samples at CLKS_PER_BIT/2; if RXD=1 the start was a glitch, return to RX_IDLE with no byte.
  - RX_DATA: 8 bits, LSB first, each sampled every CLKS_PER_BIT cycles.
  - RX_STOP: samples the stop bit. Stop=1 gives a one-cycle BYTE_VALID. Stop=0 is a framing error: byte discarded, LOAD_ERR=1.
- Loader FSM, advanced on BYTE_VALID:
  - CNT_HI: byte -> count[15:8].
  - CNT_LO: byte -> count[7:0]. Count N=0 goes to DONE next cycle; else DAT_HI.
  - DAT_HI: byte -> word[15:8].
  - DAT_LO: byte -> word[7:0], then WRITE.
  - WRITE (1 cycle): MW_IO_ON=1. WADDR_IO = BASE_ADDR + i, wrapping mod 2^16. DATA_IN_IO = word. Increment i. If i reaches N go to DONE, else DAT_HI.
  - DONE: CPU_HOLD=0, LOAD_DONE=1 from the cycle after the last write; all further bytes ignored.
  - ERROR: entered on any LOAD_ERR. CPU_HOLD stays 1; only RST exits.
- WADDR_IO / DATA_IN_IO hold their last values outside WRITE. MW_IO_ON is never high two consecutive cycles.
- Latency: stop-bit sample -> BYTE_VALID 1 cycle; BYTE_VALID of low byte -> MW_IO_ON 1 cycle.
- Minimum byte spacing (back-to-back frames) must be sustained with no byte loss.

Optional Feature:
- Macro LOADER_VERIFY_EN.
- Defined:
  - In the WRITE cycle, RADDR_IO = the written address.
  - DATA_OUT_IO is valid two cycles later (VERIFY state). A mismatch with the written word sets LOAD_ERR and enters ERROR.
  - Adds 2 cycles per word before accepting the next byte; RX keeps receiving meanwhile and holds at most one byte pending.
- Undefined: no read port activity, RADDR_IO=0, DATA_OUT_IO ignored.

Test Plan:
- Bench setting: CLKS_PER_BIT=4.
- Reset -> CPU_HOLD=1, MW_IO_ON=0, WADDR_IO=0000, LOAD_DONE=0 on the first cycle after RST.
- Send 00 02 12 34 AB CD back-to-back -> MW_IO_ON pulses twice: (0000,1234) then (0001,ABCD); CPU_HOLD=0 and LOAD_DONE=1 the cycle after the second pulse.
- Send 00 00 -> no write pulse; LOAD_DONE=1, CPU_HOLD=0. A following byte 55 is ignored.
- RXD low for 1 cycle only (glitch), then 00 01 BE EF -> single write (0000,BEEF), no error.
- Frame with stop bit 0 during the data phase -> LOAD_ERR=1, CPU_HOLD stays 1, no further writes. RST then clears everything.
- BASE_ADDR=FFFF, send 00 02 11 11 22 22 -> writes (FFFF,1111) and (0000,2222). With LOADER_VERIFY_EN and memory returning 0000 -> LOAD_ERR=1 after the first write.
